// File: rtl/sram_controller.sv
// Word-wide SRAM controller: one timed write, or a two-word (64-bit) read of an
// aligned word pair, per request. Each SRAM word access is held for SRAM_WAIT_CYCLES cycles.
module sram_controller #(
    parameter int unsigned SRAM_WAIT_CYCLES = 5,
    parameter int unsigned BASE_ADDR        = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [63:0] rdata,
    output logic        ready,
    output logic        SRAM_WE_N,
    output logic [16:0] SRAM_ADDR,
    inout  wire  [31:0] SRAM_DQ
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned AW    = 17;
    localparam int unsigned DW    = 32;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_LO,
        READ_HI,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [63:0]      rdata_d;
    logic             we_n_d;
    logic             oe_q, oe_d;
    logic [AW-1:0]    addr_d;
    logic [AW-1:0]    req_idx;
    logic             cnt_last;

    // Word index of the incoming request, relative to the data-memory base.
    assign req_idx  = AW'((address - 32'(BASE_ADDR)) >> 2);
    assign cnt_last = (cnt_q == CNT_LAST);
    assign SRAM_DQ  = oe_q ? wdata_q : {DW{1'bz}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            rdata     <= '0;
            SRAM_WE_N <= 1'b1;
            oe_q      <= 1'b0;
            SRAM_ADDR <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            rdata     <= rdata_d;
            SRAM_WE_N <= we_n_d;
            oe_q      <= oe_d;
            SRAM_ADDR <= addr_d;
        end
    end

    // Next state plus next-cycle SRAM pin values, so the pins are registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata;
        ready   = 1'b0;
        we_n_d  = 1'b1;
        oe_d    = 1'b0;
        addr_d  = SRAM_ADDR;

        case (state_q)
            IDLE: begin
                ready = ~(wr_en | rd_en);
                cnt_d = '0;
                if (wr_en) begin
                    state_d = WRITE;
                    idx_d   = req_idx;
                    wdata_d = wdata;
                end else if (rd_en) begin
                    state_d = READ_LO;
                    idx_d   = req_idx;
                end
            end
            WRITE: begin
                if (cnt_last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            READ_LO: begin
                if (cnt_last) begin
                    rdata_d[31:0] = SRAM_DQ;
                    state_d       = READ_HI;
                    cnt_d         = '0;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            READ_HI: begin
                if (cnt_last) begin
                    rdata_d[63:32] = SRAM_DQ;
                    state_d        = DONE;
                    cnt_d          = '0;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Write strobe releases in the final cycle so data is held past WE_N rising.
        case (state_d)
            WRITE: begin
                oe_d   = 1'b1;
                addr_d = idx_d;
                we_n_d = (cnt_d == CNT_LAST);
            end
            READ_LO: addr_d = {idx_d[AW-1:1], 1'b0};
            READ_HI: addr_d = {idx_d[AW-1:1], 1'b1};
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: default timing instance plus a
// SRAM_WAIT_CYCLES=2 instance, each with its own behavioural SRAM.
module tb_sram_controller;

    typedef struct {
        int unsigned lat;
        int unsigned we_low;
        logic [16:0] first_addr;
        logic [63:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        wr_en, rd_en;
    logic [31:0] address, wdata;
    logic        rd_drive;
    logic        ld_en;
    logic [7:0]  ld_a;
    logic [31:0] ld_d;

    logic [63:0] rdata0, rdata1;
    logic        ready0, ready1, we_n0, we_n1;
    logic [16:0] addr0, addr1;
    wire  [31:0] dq0, dq1;

    logic [31:0] mem0 [0:255];
    logic [31:0] mem1 [0:255];

    logic [63:0] cur_rdata;
    logic        cur_ready, cur_we_n;
    logic [16:0] cur_addr;
    logic [31:0] cur_dq;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sram_controller #(.SRAM_WAIT_CYCLES(5), .BASE_ADDR(1024)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en & ~sel), .rd_en(rd_en & ~sel),
        .address(address), .wdata(wdata), .rdata(rdata0), .ready(ready0),
        .SRAM_WE_N(we_n0), .SRAM_ADDR(addr0), .SRAM_DQ(dq0)
    );

    sram_controller #(.SRAM_WAIT_CYCLES(2), .BASE_ADDR(1024)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en & sel), .rd_en(rd_en & sel),
        .address(address), .wdata(wdata), .rdata(rdata1), .ready(ready1),
        .SRAM_WE_N(we_n1), .SRAM_ADDR(addr1), .SRAM_DQ(dq1)
    );

    // Behavioural SRAMs: drive the bus only while a read is in flight.
    assign dq0 = (rd_drive && !sel) ? mem0[addr0[7:0]] : 32'hzzzz_zzzz;
    assign dq1 = (rd_drive &&  sel) ? mem1[addr1[7:0]] : 32'hzzzz_zzzz;

    always_ff @(posedge clk) begin
        if (!we_n0) mem0[addr0[7:0]] <= dq0;
        if (!we_n1) mem1[addr1[7:0]] <= dq1;
        if (ld_en && !sel) mem0[ld_a] <= ld_d;
        if (ld_en &&  sel) mem1[ld_a] <= ld_d;
    end

    assign cur_rdata = sel ? rdata1 : rdata0;
    assign cur_ready = sel ? ready1 : ready0;
    assign cur_we_n  = sel ? we_n1  : we_n0;
    assign cur_addr  = sel ? addr1  : addr0;
    assign cur_dq    = sel ? dq1    : dq0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        ld_a  = a;
        ld_d  = d;
        ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic check_idle_pins(input string tag);
        check({tag, "_ready"}, 64'(cur_ready), 64'd1);
        check({tag, "_we_n"}, 64'(cur_we_n), 64'd1);
        check({tag, "_dq_z"}, {32'd0, cur_dq}, {32'd0, 32'hzzzz_zzzz});
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the DONE negedge.
    task automatic do_op(input string tag, input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d,
                         input int unsigned e_lat, input int unsigned e_we,
                         input logic [16:0] e_addr, input logic [63:0] e_rd);
        exp_t        e;
        int unsigned lat, we_low;
        logic [16:0] fa;
        sb.push_back('{lat: e_lat, we_low: e_we, first_addr: e_addr, rdata: e_rd});
        rd_drive = r & ~w;
        address  = a;
        wdata    = d;
        wr_en    = w;
        rd_en    = r;
        #1;
        lat    = 0;
        we_low = 0;
        fa     = '0;
        while (!cur_ready && lat < 64) begin
            lat++;
            if (lat == 2) fa = cur_addr;
            if (!cur_we_n) we_low++;
            @(negedge clk);
        end
        e = sb.pop_front();
        check({tag, "_latency"}, 64'(lat), 64'(e.lat));
        check({tag, "_we_low"}, 64'(we_low), 64'(e.we_low));
        check({tag, "_sram_addr"}, 64'(fa), 64'(e.first_addr));
        check({tag, "_rdata"}, cur_rdata, e.rdata);
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        rd_drive = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; sel = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        address = '0; wdata = '0; rd_drive = 1'b0;
        ld_en = 1'b0; ld_a = '0; ld_d = '0;
        repeat (2) @(negedge clk);
        check_idle_pins("reset");
        check("reset_rdata", rdata0, 64'd0);
        check("reset_addr", 64'(addr0), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_idle_pins("idle");

        load(8'd4, 32'h1111_1111);
        load(8'd5, 32'h2222_2222);

        do_op("wr1032", 1'b1, 1'b0, 32'd1032, 32'hDEAD_BEEF, 6, 4, 17'd2, 64'd0);
        check("mem_word2", 64'(mem0[2]), 64'hDEAD_BEEF);
        @(negedge clk);
        do_op("rd1044", 1'b0, 1'b1, 32'd1044, 32'd0, 11, 0, 17'd4, 64'h2222_2222_1111_1111);
        @(negedge clk);
        do_op("both1024", 1'b1, 1'b1, 32'd1024, 32'hCAFE_F00D, 6, 4, 17'd0, 64'h2222_2222_1111_1111);
        check("mem_word0", 64'(mem0[0]), 64'hCAFE_F00D);

        // Back-to-back: exactly one IDLE cycle between DONE and the next access.
        @(negedge clk);
        do_op("b2b_wr", 1'b1, 1'b0, 32'd1036, 32'hA5A5_A5A5, 6, 4, 17'd3, 64'h2222_2222_1111_1111);
        @(negedge clk);
        check_idle_pins("gap");
        do_op("b2b_rd", 1'b0, 1'b1, 32'd1032, 32'd0, 11, 0, 17'd2, 64'hA5A5_A5A5_DEAD_BEEF);

        // Reset asserted in the third READ_LO cycle aborts the access.
        @(negedge clk);
        rd_drive = 1'b1; address = 32'd1044; rd_en = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_abort_ready", 64'(cur_ready), 64'd0);
        rst = 1'b0; rd_drive = 1'b0; rd_en = 1'b0;
        #1;
        check("abort_rdata", rdata0, 64'd0);
        check("abort_addr", 64'(addr0), 64'd0);
        check_idle_pins("abort");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_op("rd_after_rst", 1'b0, 1'b1, 32'd1044, 32'd0, 11, 0, 17'd4, 64'h2222_2222_1111_1111);

        // Shortest legal wait time.
        @(negedge clk);
        sel = 1'b1;
        load(8'd0, 32'h0BAD_F00D);
        do_op("w2_wr", 1'b1, 1'b0, 32'd1028, 32'h1234_5678, 3, 1, 17'd1, 64'd0);
        check("w2_mem_word1", 64'(mem1[1]), 64'h1234_5678);
        @(negedge clk);
        do_op("w2_rd", 1'b0, 1'b1, 32'd1024, 32'd0, 5, 0, 17'd0, 64'h1234_5678_0BAD_F00D);
        @(negedge clk);
        check_idle_pins("w2_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
